ifu_fetch_queue: RTL and testbench

- Instruction-fetch stage directly upstream of the decoder.
- Owns the PC, issues in-order 32-bit fetch requests to instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry FIFO.
- Presents one instruction per cycle to decode. Drives the bubble encoding (32'h0000_0000) whenever nothing valid is available.
- Handles branch/jump redirects by flushing the queue and discarding stale in-flight responses.

---
 rtl/ifu_fetch_queue.sv | 115 +++++++++++
 tb/tb_ifu_fetch_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order fetches and
// buffers returned instructions with their PCs for the decoder. Redirects flush and kill.
module ifu_fetch_queue #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            id_stall,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [PC_W-1:0] id_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    logic [PC_W-1:0] pc;
    logic [CW-1:0]   occ, outstanding, kill;
    logic [CW-1:0]   occ_next, out_next;
    logic [AW-1:0]   q_head, q_tail, f_head, f_tail;
    logic            req_enable;

    logic [31:0]     q_instr [DEPTH];
    logic [PC_W-1:0] q_pc    [DEPTH];
    logic [PC_W-1:0] f_pc    [DEPTH];

    logic accept, resp_fire, push, pop;
    logic unused_redirect_low;

    assign unused_redirect_low = ^redirect_pc[1:0];

    // Credit covers both buffered entries and responses still owed by memory,
    // so a response always finds a free slot.
    assign imem_req_valid = rst_n && req_enable &&
                            (({1'b0, occ} + {1'b0, outstanding}) < DEPTH_W);
    assign imem_req_addr  = pc;

    assign accept    = imem_req_valid && imem_req_ready;
    assign resp_fire = imem_resp_valid && (outstanding != '0);
    assign push      = resp_fire && (kill == '0) && !redirect_valid;

    assign id_valid  = (occ != '0) && !redirect_valid;
    assign pop       = id_valid && !id_stall;
    assign id_instr  = id_valid ? q_instr[q_head] : 32'h0;
    assign id_pc     = id_valid ? q_pc[q_head] : '0;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        out_next = outstanding;
        if (accept)    out_next = out_next + CW'(1);
        if (resp_fire) out_next = out_next - CW'(1);
        occ_next = occ;
        if (push) occ_next = occ_next + CW'(1);
        if (pop)  occ_next = occ_next - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            occ         <= '0;
            outstanding <= '0;
            kill        <= '0;
            q_head      <= '0;
            q_tail      <= '0;
            f_head      <= '0;
            f_tail      <= '0;
            req_enable  <= 1'b0;
        end else begin
            req_enable  <= 1'b1;
            outstanding <= out_next;
            if (accept)    f_tail <= f_tail + AW'(1);
            if (resp_fire) f_head <= f_head + AW'(1);

            if (redirect_valid) begin
                // Everything still owed by memory, including this cycle's accept, is stale.
                pc     <= {redirect_pc[PC_W-1:2], 2'b00};
                occ    <= '0;
                q_head <= '0;
                q_tail <= '0;
                kill   <= out_next;
            end else begin
                if (accept) pc <= pc + PC_W'(4);
                if (resp_fire && (kill != '0)) kill <= kill - CW'(1);
                if (push) q_tail <= q_tail + AW'(1);
                if (pop)  q_head <= q_head + AW'(1);
                occ <= occ_next;
            end
        end
    end

    // NOTE: storage arrays are not reset; pointers and counts alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[q_tail] <= imem_resp_data;
            q_pc[q_tail]    <= f_pc[f_head];
        end
        if (accept) f_pc[f_tail] <= pc;
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_resp_valid && (outstanding == '0)));
    assert property (@(posedge clk) disable iff (!rst_n)
        (occ <= DEPTH_C) && (outstanding <= DEPTH_C) && (kill <= DEPTH_C));

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: a latency-configurable memory model and an
// epoch-tagged scoreboard of expected decoder-side {pc, instr} entries.
module tb_ifu_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          PC_W     = 64;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [63:0] id_pc;

    ifu_fetch_queue #(.PC_W(PC_W), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_stall(id_stall), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; int epoch; int due; } mem_req_t;
    typedef struct { logic [63:0] pc; logic [31:0] instr; } exp_t;

    mem_req_t    memq[$];
    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          lat = 1;
    int          acc_count = 0;
    int          pop_count = 0;
    bit          after_reset = 1'b0;
    logic [63:0] exp_pc = RESET_PC;

    logic        s_req_valid, s_accept, s_id_valid;
    logic [63:0] s_addr, s_id_pc;
    logic [31:0] s_id_instr;
    int          s_cyc;

    function automatic logic [31:0] data_of(input logic [63:0] a);
        return {a[26:2], 7'h13};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample #1 later, advance the model at posedge.
    task automatic step(input logic ready, input logic stall, input logic redir,
                        input logic [63:0] rpc);
        logic     resp_now, exp_valid, exp_req;
        mem_req_t m;
        exp_t     e;
        imem_req_ready = ready;
        id_stall       = stall;
        redirect_valid = redir;
        redirect_pc    = rpc;
        resp_now       = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_resp_valid = resp_now;
        imem_resp_data  = resp_now ? data_of(memq[0].addr) : 32'h0;
        #1;
        exp_req   = !after_reset && ((sb.size() + memq.size()) < DEPTH);
        exp_valid = (sb.size() > 0) && !redir;
        check("req_valid", 64'(imem_req_valid), 64'(exp_req));
        check("req_addr", imem_req_addr, exp_pc);
        check("id_valid", 64'(id_valid), 64'(exp_valid));
        if (exp_valid) begin
            check("id_pc", id_pc, sb[0].pc);
            check("id_instr", 64'(id_instr), 64'(sb[0].instr));
        end else begin
            check("id_pc_zero", id_pc, 64'h0);
            check("id_instr_zero", 64'(id_instr), 64'h0);
        end
        s_req_valid = imem_req_valid;
        s_accept    = imem_req_valid && ready;
        s_addr      = imem_req_addr;
        s_id_valid  = id_valid;
        s_id_pc     = id_pc;
        s_id_instr  = id_instr;
        s_cyc       = cyc;
        @(posedge clk);
        if (exp_valid && !stall) begin
            e = sb.pop_front();
            pop_count++;
        end
        if (resp_now) begin
            m = memq.pop_front();
            if ((m.epoch == epoch) && !redir) sb.push_back('{pc: m.addr, instr: data_of(m.addr)});
        end
        if (s_accept) begin
            memq.push_back('{addr: s_addr, epoch: epoch, due: cyc + lat});
            exp_pc = exp_pc + 64'd4;
            acc_count++;
        end
        if (redir) begin
            sb.delete();
            epoch++;
            exp_pc = {rpc[63:2], 2'b00};
        end
        after_reset = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 64'h0; id_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        memq.delete();
        exp_pc = RESET_PC;
        after_reset = 1'b1;
        cyc++;
    endtask

    // Free-running fetch; reports the first accepted address and first delivered PC.
    task automatic run_collect(input int n, output logic [63:0] first_addr,
                               output logic [63:0] first_pc);
        bit got_a, got_v;
        got_a = 1'b0; got_v = 1'b0;
        first_addr = '1; first_pc = '1;
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 64'h0);
            if (s_accept && !got_a) begin first_addr = s_addr; got_a = 1'b1; end
            if (s_id_valid && !got_v) begin first_pc = s_id_pc; got_v = 1'b1; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] fa, fp, hold, prev_pc;
        int          first_acc, first_val;
        bit          prev_v, found;

        // Power-on reset and steady streaming with 1-cycle memory latency.
        do_reset();
        lat = 1; first_acc = -1; first_val = -1; prev_v = 1'b0; fp = '1; prev_pc = '0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b0, 64'h0);
            if (s_accept && first_acc < 0) first_acc = s_cyc;
            if (s_id_valid && first_val < 0) begin first_val = s_cyc; fp = s_id_pc; end
            if (s_id_valid && prev_v) check("pc_stride", s_id_pc, prev_pc + 64'd4);
            prev_v = s_id_valid; prev_pc = s_id_pc;
        end
        check("first_valid_latency", 64'(first_val - first_acc), 64'd2);
        check("first_id_pc", fp, RESET_PC);

        // Decode stall: credit stops fetch after DEPTH requests, head stays put.
        do_reset();
        acc_count = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 64'h0);
        check("stall_accepts", 64'(acc_count), 64'd4);
        check("stall_req_valid_low", 64'(s_req_valid), 64'd0);
        check("stall_head_pc", s_id_pc, RESET_PC);
        pop_count = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 64'h0);
        check("release_pops", 64'(pop_count), 64'd4);

        // Redirect with two requests in flight; misaligned target is word-aligned.
        do_reset();
        lat = 3;
        step(1'b0, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b0, 1'b0, 1'b1, 64'h0000_0000_8000_0102);
        lat = 1;
        run_collect(10, fa, fp);
        check("redir_first_addr", fa, 64'h0000_0000_8000_0100);
        check("redir_first_pc", fp, 64'h0000_0000_8000_0100);

        // Redirect coinciding with a response and an accept.
        step(1'b1, 1'b0, 1'b1, 64'h0000_0000_8000_0200);
        check("coincide_accept", 64'(s_accept), 64'd1);
        check("coincide_id_valid", 64'(s_id_valid), 64'd0);
        check("coincide_id_instr", 64'(s_id_instr), 64'd0);
        run_collect(8, fa, fp);
        check("coincide_first_pc", fp, 64'h0000_0000_8000_0200);

        // Back-to-back redirects with longer latency: kill must cover every stale response.
        lat = 3;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b0, 1'b1, 64'h0000_0000_8000_0300);
        step(1'b1, 1'b0, 1'b1, 64'h0000_0000_8000_0400);
        run_collect(16, fa, fp);
        check("b2b_first_pc", fp, 64'h0000_0000_8000_0400);

        // Memory not ready: queue drains, outputs bubble, pc holds.
        lat = 1;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 64'h0);
        hold = exp_pc;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 64'h0);
            check("idle_id_valid", 64'(s_id_valid), 64'd0);
            check("idle_pc_hold", s_addr, hold);
        end

        // Reset mid-operation with three entries queued and one outstanding.
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (sb.size() == 3 && memq.size() == 1) found = 1'b1;
            else step(1'b1, 1'b1, 1'b0, 64'h0);
        end
        check("fill_state_reached", 64'(found), 64'd1);
        do_reset();
        acc_count = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 64'h0);
        check("reset_credit_restored", 64'(acc_count), 64'd4);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 64'h0);
        check("final_idle", 64'(s_id_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
